// File: rtl/mure_retire_sequencer.sv
// Drains one multi-lane commit group into a single-lane consumer, one lane per handshake,
// skipping invalid lanes, truncating after a terminating lane and popping the group once.
module mure_retire_sequencer #(
  parameter int NRET  = 2,
  parameter int CNT_W = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            empty_i,
  input  logic [NRET-1:0]                 lane_valid_i,
  input  logic [NRET-1:0]                 lane_term_i,
  input  logic                            flush_i,
  input  logic                            out_ready_i,
  output logic                            out_valid_o,
  output logic [$clog2(NRET)-1:0]         sel_o,
  output logic                            last_o,
  output logic                            pop_o,
  output logic                            busy_o,
  output logic [CNT_W-1:0]                groups_o,
  output logic [CNT_W-1:0]                dropped_o
);

  localparam int SW = $clog2(NRET);

  typedef enum logic {
    IDLE,
    ISSUE
  } state_t;

  state_t            state_reg, state_next;
  logic [NRET-1:0]   done_reg, done_next;
  logic [CNT_W-1:0]  groups_reg, groups_next;
  logic [CNT_W-1:0]  dropped_reg, dropped_next;

  logic [NRET-1:0]   pend;
  logic [NRET-1:0]   above_mask;
  logic [NRET-1:0]   pend_above;
  logic [SW-1:0]     sel;
  logic              last;
  logic              issue;
  logic              pop_req;

  function automatic logic [CNT_W-1:0] popcnt(input logic [NRET-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NRET; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign pend = lane_valid_i & ~done_reg;

  // Lowest pending lane wins; scanning downward leaves the smallest index last.
  always_comb begin
    sel = '0;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (pend[i]) sel = SW'(i);
    end
  end

  generate
    for (genvar gi = 0; gi < NRET; gi++) begin : g_above
      assign above_mask[gi] = (SW'(gi) > sel);
    end
  endgenerate

  assign pend_above  = pend & above_mask;
  assign last        = (pend_above == '0) || lane_term_i[sel];
  assign issue       = (state_reg == ISSUE);

  // Everything visible is qualified by ISSUE so an async reset clears outputs at once.
  assign out_valid_o = issue && (pend != '0) && !flush_i;
  assign sel_o       = out_valid_o ? sel : '0;
  assign last_o      = out_valid_o && last;
  assign pop_o       = pop_req && !empty_i;
  assign busy_o      = issue;
  assign groups_o    = groups_reg;
  assign dropped_o   = dropped_reg;

  always_comb begin
    state_next   = state_reg;
    done_next    = done_reg;
    groups_next  = groups_reg;
    dropped_next = dropped_reg;
    pop_req      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty_i) state_next = ISSUE;
      end
      ISSUE: begin
        if (flush_i) begin
          pop_req      = 1'b1;
          dropped_next = sat_add(dropped_reg, popcnt(pend));
          done_next    = '0;
          state_next   = IDLE;
        end else if (pend == '0) begin
          pop_req    = 1'b1;
          done_next  = '0;
          state_next = IDLE;
        end else if (out_ready_i) begin
          if (last) begin
            pop_req     = 1'b1;
            done_next   = '0;
            groups_next = sat_add(groups_reg, CNT_W'(1));
            if (lane_term_i[sel]) dropped_next = sat_add(dropped_reg, popcnt(pend_above));
            state_next  = IDLE;
          end else begin
            done_next[sel] = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      done_reg    <= '0;
      groups_reg  <= '0;
      dropped_reg <= '0;
    end else begin
      state_reg   <= state_next;
      done_reg    <= done_next;
      groups_reg  <= groups_next;
      dropped_reg <= dropped_next;
    end
  end

  a_pop_single : assert property (@(posedge clk_i) disable iff (rst_i)
    pop_o |=> !pop_o);

  a_valid_hold : assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i) |=> (flush_i || (out_valid_o && $stable(sel_o))));

  a_sel_valid : assert property (@(posedge clk_i) disable iff (rst_i)
    out_valid_o |-> lane_valid_i[sel_o]);

endmodule

// File: doc/mure_retire_sequencer.md
Name: mure_retire_sequencer

Overview:
- Sequencer that drains the per-commit-port uop FIFOs of the multiple-retirement datapath into the single-packet FSM, one lane per handshake.
- The commit-port FIFOs are pushed and popped together; one FIFO row holding NRET lanes is one "group".
- The block replaces free-running counter selection with a valid-aware, backpressure-aware scheduler:
  - skips invalid lanes;
  - truncates a group after an exception/interrupt lane;
  - issues the group-level FIFO pop.

Parameters:
- NRET, 2, number of commit ports (lanes per group); legal range 2..8.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- empty_i  in  1  FIFO empty flag (all lane FIFOs share occupancy).
- lane_valid_i  in  NRET  per-lane uop valid bit at the FIFO head.
- lane_term_i  in  NRET  per-lane terminate flag: head itype is EXC or INT.
- flush_i  in  1  discard the current group.
- out_ready_i  in  1  downstream FSM accepts the lane.
- out_valid_o  out  1  a lane is presented.
- sel_o  out  $clog2(NRET)  mux select for the lane presented.
- last_o  out  1  presented lane is the final one of its group.
- pop_o  out  1  single-cycle pop of all lane FIFOs.
- busy_o  out  1  FSM in ISSUE state.
- groups_o  out  CNT_W  groups retired (saturating).
- dropped_o  out  CNT_W  valid lanes discarded by terminate/flush (saturating).

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, done mask=0.
  - All outputs 0: out_valid_o, sel_o, last_o, pop_o, busy_o, groups_o, dropped_o.
- Definitions:
  - pend = lane_valid_i & ~done.
  - sel = lowest set bit of pend, via combinational priority encoder.
  - After sel, remaining lanes are those at indices above sel.
- last_o = (no pend bit above sel) OR lane_term_i[sel].
- State IDLE:
  - out_valid_o=0.
  - If !empty_i: go to ISSUE next cycle.
  - This gives 1 cycle of latency from the FIFO going non-empty to the first presented lane.
- State ISSUE, outputs:
  - out_valid_o = (pend != 0) and !flush_i.
  - sel_o = sel.
- State ISSUE, transfer (out_valid_o & out_ready_i):
  - If !last_o: set done[sel]. The next lane appears the next cycle, so the zero-cycle skip over invalid lanes gives 1 lane/cycle throughput.
  - If last_o: pop_o=1 in the same cycle, done cleared, groups_o++.
  - If last_o was caused by lane_term_i: dropped_o += popcount of valid lanes above sel.
  - After a last_o transfer: if FIFO usage allows (!empty_i after pop is unknown), return to IDLE. Back-to-back groups therefore incur 1 bubble cycle.
- Backpressure: with out_ready_i=0, sel_o, last_o and out_valid_o are held stable. Inputs are FIFO heads, so they are stable while no pop occurs.
- Empty group (ISSUE with pend==0, including all lane_valid_i=0):
  - pop_o=1, done cleared, return to IDLE.
  - No output and no groups_o increment.
- flush_i=1 in ISSUE:
  - out_valid_o forced 0.
  - pop_o=1; dropped_o += popcount(pend).
  - done cleared, go to IDLE. flush_i has priority over a concurrent transfer.
- flush_i in IDLE: no effect.
- pop_o never asserted while empty_i=1.
- Counters saturate at all-ones; no wrap.
- busy_o = (state==ISSUE).
- Reset mid-group: done cleared. The group is re-issued from its lowest valid lane after reset, because FIFO contents are owned by their own reset.
- SVA:
  - pop_o is single-cycle per group.
  - out_valid_o held until out_ready_i.
  - sel_o always indexes a lane_valid_i bit when out_valid_o=1.

Test Plan:
1. NRET=2, one group lane_valid=11, term=00, ready=1 → sel_o 0 then 1; last_o on 2nd cycle; pop_o with it; groups_o=1, dropped_o=0.
2. NRET=4, lane_valid=1010, ready=1 → only sel_o=1 then 3; lanes 0 and 2 skipped with no bubble; pop_o on lane 3.
3. NRET=4, valid=1111, term=0010 → sel_o 0, 1 (last_o=1); pop_o; dropped_o=2; lanes 2 and 3 never presented.
4. Backpressure: valid=11, ready low 3 cycles at lane 0 → out_valid_o=1, sel_o=0 stable for 3 cycles; no pop; completes normally after ready rises.
5. flush_i during lane 1 of a 4-valid group with out_ready_i=1 → out_valid_o=0, pop_o=1, dropped_o=3, state IDLE.
6. dropped_o preloaded to 0xFFFE by repeated terminate groups → saturates at 0xFFFF. Async rst_i mid-group → all outputs 0 immediately, without waiting for a clock edge.
